// File: rtl/f2_cmd_scheduler.sv
// F2 GPU front-end: debounced buttons, per-command pending flags, fixed-priority ISSUE/GAP/WAIT sequencer.
// Optional slideshow auto-advance is compiled in with `define F2_AUTO_SLIDE_EN.
module f2_cmd_scheduler #(
  parameter int DB_W         = 20,
  parameter int DB_CYCLES    = 500000,
  parameter int HOLD_CYCLES  = 4,
  parameter int GAP_CYCLES   = 4,
  parameter int SLIDE_W      = 28,
  parameter int SLIDE_CYCLES = 100000000
) (
  input  logic       sysclk,
  input  logic       sys_rst_n,
  input  logic [3:0] btn,
  input  logic       gpu_busy,
  input  logic       slide_en,
  output logic [2:0] instruction,
  output logic [3:0] cmd_ack,
  output logic [3:0] pending,
  output logic       sched_busy
);

  localparam int PH_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);

  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DB_CYCLES - 1);
  localparam logic [PH_W-1:0] HOLD_LAST = PH_W'(HOLD_CYCLES - 1);
  localparam logic [PH_W-1:0] GAP_LAST  = PH_W'(GAP_CYCLES - 1);
  localparam logic [PH_W-1:0] WAIT_LAST = PH_W'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, GAP, WAIT} state_t;

  state_t           state, state_nxt;
  logic [3:0]       btn_p0, btn_p1;
  logic [3:0]       stable, stable_prev;
  logic [DB_W-1:0]  db_cnt [4];
  logic [3:0]       press;
  logic [PH_W-1:0]  phase_cnt, phase_nxt;
  logic             busy_seen, seen_nxt;
  logic [2:0]       code_q, code_nxt;
  logic [2:0]       instr_nxt;
  logic [3:0]       ack_nxt;
  logic [3:0]       pend_clr;
  logic             slide_fire;

  // Lowest set bit wins: prev > next > rotate > negative.
  function automatic logic [1:0] prio_pick(input logic [3:0] req);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (req[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // Stage p0/p1: two-flop synchronizer, then per-button debounce.
  always_ff @(posedge sysclk) begin
    if (!sys_rst_n) begin
      btn_p0      <= '0;
      btn_p1      <= '0;
      stable      <= '0;
      stable_prev <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      btn_p0      <= btn;
      btn_p1      <= btn_p0;
      stable_prev <= stable;
      for (int i = 0; i < 4; i++) begin
        if (btn_p1[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          stable[i] <= btn_p1[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  assign press = stable & ~stable_prev;

`ifdef F2_AUTO_SLIDE_EN
  localparam logic [SLIDE_W-1:0] SLIDE_LAST = SLIDE_W'(SLIDE_CYCLES - 1);

  logic [SLIDE_W-1:0] slide_cnt;
  logic               slide_run;

  assign slide_run  = (state == IDLE) && (pending == 4'b0000) && !gpu_busy && slide_en;
  assign slide_fire = slide_run && (slide_cnt == SLIDE_LAST);

  // Interval restarts on any accepted press or whenever a sequence starts.
  always_ff @(posedge sysclk) begin
    if (!sys_rst_n) begin
      slide_cnt <= '0;
    end else if ((press != 4'b0000) || slide_fire || ((state == IDLE) && (state_nxt != IDLE))) begin
      slide_cnt <= '0;
    end else if (slide_run) begin
      slide_cnt <= slide_cnt + SLIDE_W'(1);
    end
  end
`else
  logic unused_slide;

  assign slide_fire   = 1'b0;
  assign unused_slide = slide_en ^ (SLIDE_W == 0) ^ (SLIDE_CYCLES == 0);
`endif

  always_comb begin
    state_nxt = state;
    phase_nxt = phase_cnt;
    seen_nxt  = busy_seen;
    code_nxt  = code_q;
    instr_nxt = 3'd0;
    ack_nxt   = 4'b0000;
    pend_clr  = 4'b0000;
    case (state)
      IDLE: begin
        phase_nxt = '0;
        seen_nxt  = 1'b0;
        if ((pending != 4'b0000) && !gpu_busy) begin
          state_nxt = ISSUE;
          instr_nxt = {1'b0, prio_pick(pending)} + 3'd1;
          ack_nxt   = 4'b0001 << prio_pick(pending);
          pend_clr  = 4'b0001 << prio_pick(pending);
          code_nxt  = instr_nxt;
        end else if (slide_fire) begin
          state_nxt = ISSUE;
          instr_nxt = 3'd2;
          ack_nxt   = 4'b0010;
          code_nxt  = 3'd2;
        end
      end
      ISSUE: begin
        if (phase_cnt == HOLD_LAST) begin
          state_nxt = GAP;
          phase_nxt = '0;
        end else begin
          phase_nxt = phase_cnt + PH_W'(1);
          instr_nxt = instruction;
        end
      end
      GAP: begin
        if (phase_cnt == GAP_LAST) begin
          phase_nxt = '0;
          state_nxt = ((code_q == 3'd1) || (code_q == 3'd2)) ? WAIT : IDLE;
        end else begin
          phase_nxt = phase_cnt + PH_W'(1);
        end
      end
      WAIT: begin
        // Two-cycle window for the GPU to raise busy; once seen, wait for it to drop.
        if (gpu_busy) begin
          seen_nxt = 1'b1;
        end else if (busy_seen || (phase_cnt == WAIT_LAST)) begin
          state_nxt = IDLE;
          phase_nxt = '0;
        end else begin
          phase_nxt = phase_cnt + PH_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        phase_nxt = '0;
      end
    endcase
  end

  // Stage p2: FSM state and registered outputs.
  always_ff @(posedge sysclk) begin
    if (!sys_rst_n) begin
      state       <= IDLE;
      phase_cnt   <= '0;
      busy_seen   <= 1'b0;
      code_q      <= 3'd0;
      instruction <= 3'd0;
      cmd_ack     <= 4'b0000;
      pending     <= 4'b0000;
    end else begin
      state       <= state_nxt;
      phase_cnt   <= phase_nxt;
      busy_seen   <= seen_nxt;
      code_q      <= code_nxt;
      instruction <= instr_nxt;
      cmd_ack     <= ack_nxt;
      pending     <= (pending & ~pend_clr) | press;
    end
  end

  assign sched_busy = (state != IDLE);

endmodule

// File: tb/tb_f2_cmd_scheduler.sv
// Directed bench for f2_cmd_scheduler with short debounce/hold/gap settings.
module tb_f2_cmd_scheduler;

  logic       sysclk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [3:0] btn = 4'b0000;
  logic       gpu_busy = 1'b0;
  logic       slide_en = 1'b0;
  logic [2:0] instruction;
  logic [3:0] cmd_ack;
  logic [3:0] pending;
  logic       sched_busy;

  int total = 0;
  int bad   = 0;
  int seq[$];
  logic any_nz;
  logic found;

  f2_cmd_scheduler #(
    .DB_W(4), .DB_CYCLES(4), .HOLD_CYCLES(2), .GAP_CYCLES(2),
    .SLIDE_W(8), .SLIDE_CYCLES(50)
  ) dut (
    .sysclk(sysclk), .sys_rst_n(sys_rst_n), .btn(btn), .gpu_busy(gpu_busy),
    .slide_en(slide_en), .instruction(instruction), .cmd_ack(cmd_ack),
    .pending(pending), .sched_busy(sched_busy)
  );

  always #5 sysclk = ~sysclk;

  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Steps one edge per entry, checking instruction and the cmd_ack pulse expected on each 0->code edge.
  task automatic play(input string tag, input int exp_seq[$], input int release_at);
    int prev;
    logic [3:0] ack_exp;
    prev = 0;
    for (int k = 0; k < exp_seq.size(); k++) begin
      step();
      if (k + 1 == release_at) btn = 4'b0000;
      ack_exp = (exp_seq[k] != 0 && prev == 0) ? (4'b0001 << (exp_seq[k] - 1)) : 4'b0000;
      check($sformatf("%s_instr_e%0d", tag, k + 1), {29'd0, instruction}, exp_seq[k]);
      check($sformatf("%s_ack_e%0d", tag, k + 1), {28'd0, cmd_ack}, {28'd0, ack_exp});
      prev = exp_seq[k];
    end
  endtask

  task automatic settle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    // Reset state
    step();
    step();
    check("rst_instr", {29'd0, instruction}, 0);
    check("rst_ack", {28'd0, cmd_ack}, 0);
    check("rst_pending", {28'd0, pending}, 0);
    check("rst_busy", {31'd0, sched_busy}, 0);
    sys_rst_n = 1'b1;
    settle(2);

    // 1a: 3-cycle bounce is rejected
    btn = 4'b0100;
    seq = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    play("t1a", seq, 3);
    check("t1a_pending", {28'd0, pending}, 0);

    // 1b: held press issues rotate once
    btn = 4'b0100;
    seq = '{0, 0, 0, 0, 0, 0, 0};
    play("t1b", seq, 0);
    check("t1b_pending_set", {28'd0, pending}, 32'h4);
    seq = '{3, 3, 0, 0, 0};
    play("t1b_run", seq, 3);
    check("t1b_pending_end", {28'd0, pending}, 0);
    check("t1b_idle", {31'd0, sched_busy}, 0);
    settle(12);

    // 2: all four together, served in priority order
    btn = 4'b1111;
    seq = '{0, 0, 0, 0, 0, 0, 0};
    play("t2", seq, 0);
    check("t2_pending_set", {28'd0, pending}, 32'hF);
    seq = '{1, 1, 0, 0, 0, 0, 0, 2, 2, 0, 0, 0, 0, 0, 3, 3, 0, 0, 0, 4, 4, 0, 0, 0};
    play("t2_run", seq, 3);
    check("t2_pending_end", {28'd0, pending}, 0);
    check("t2_idle", {31'd0, sched_busy}, 0);
    settle(12);

    // 3: press held off by gpu_busy, issues one cycle after busy drops
    gpu_busy = 1'b1;
    btn = 4'b0001;
    seq = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    play("t3", seq, 10);
    check("t3_pending_held", {28'd0, pending}, 32'h1);
    check("t3_idle", {31'd0, sched_busy}, 0);
    gpu_busy = 1'b0;
    seq = '{1, 1, 0, 0, 0, 0, 0};
    play("t3_run", seq, 0);
    check("t3_pending_end", {28'd0, pending}, 0);
    check("t3_idle_end", {31'd0, sched_busy}, 0);
    settle(12);

    // 4: code 2 then GPU animates; negative waits for busy to fall
    btn = 4'b0010;
    seq = '{0, 0, 0, 0, 0, 0, 0, 2, 2, 0, 0, 0};
    play("t4", seq, 10);
    gpu_busy = 1'b1;
    btn = 4'b1000;
    for (int i = 0; i < 30; i++) begin
      step();
      if (i == 10) btn = 4'b0000;
      check($sformatf("t4_hold_instr_%0d", i), {29'd0, instruction}, 0);
      check($sformatf("t4_hold_busy_%0d", i), {31'd0, sched_busy}, 1);
    end
    check("t4_pending_neg", {28'd0, pending}, 32'h8);
    gpu_busy = 1'b0;
    seq = '{0, 4, 4, 0, 0, 0};
    play("t4_run", seq, 0);
    check("t4_idle", {31'd0, sched_busy}, 0);
    settle(12);

    // 5: reset in the middle of ISSUE, buttons held through reset
    btn = 4'b1100;
    seq = '{0, 0, 0, 0, 0, 0, 0, 3};
    play("t5", seq, 0);
    check("t5_pending_pre", {28'd0, pending}, 32'h8);
    sys_rst_n = 1'b0;
    step();
    check("t5_rst_instr", {29'd0, instruction}, 0);
    check("t5_rst_pending", {28'd0, pending}, 0);
    check("t5_rst_busy", {31'd0, sched_busy}, 0);
    check("t5_rst_ack", {28'd0, cmd_ack}, 0);
    step();
    sys_rst_n = 1'b1;
    seq = '{0, 0, 0, 0, 0, 0, 0, 3, 3, 0, 0, 0, 4, 4, 0, 0, 0};
    play("t5_run", seq, 8);
    check("t5_pending_end", {28'd0, pending}, 0);
    settle(12);

    // 6: slideshow behaviour with buttons idle
    slide_en = 1'b1;
`ifdef F2_AUTO_SLIDE_EN
    found = 1'b0;
    for (int i = 0; i < 70 && !found; i++) begin
      step();
      if (instruction != 3'd0) found = 1'b1;
    end
    check("t6_slide_code", {29'd0, instruction}, 2);
    check("t6_slide_pending", {28'd0, pending}, 0);
`else
    any_nz = 1'b0;
    for (int i = 0; i < 120; i++) begin
      step();
      if (instruction != 3'd0) any_nz = 1'b1;
    end
    check("t6_no_slide", {31'd0, any_nz}, 0);
    check("t6_idle", {31'd0, sched_busy}, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
